// File: rtl/hls_core_chn_in_rsci_fifo.sv
// rtl/hls_core_chn_in_rsci_fifo.sv - input channel FIFO with zero-latency bypass and starvation counter
module hls_core_chn_in_rsci_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rst,
  input  logic [WIDTH-1:0] chn_in_rsc_z,
  input  logic             chn_in_rsc_vz,
  output logic             chn_in_rsc_lz,
  input  logic             chn_in_rsci_oswt,
  input  logic             core_wen,
  input  logic             core_wten,
  input  logic             chn_in_rsci_ld_core_psct,
  output logic             chn_in_rsci_bawt,
  output logic             chn_in_rsci_wen_comp,
  output logic [WIDTH-1:0] chn_in_rsci_d_mxwt,
  output logic [CW-1:0]    chn_in_rsci_cnt,
  output logic [15:0]      chn_in_rsci_stall_cnt
);

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    cnt;
  logic [15:0]      stall_cnt;

  logic empty;
  logic accept;
  logic pop;
  logic wr_en;
  logic rd_en;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    ptr_next = (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Handshake and core-facing status; lz depends only on state and core controls, never on vz
  always_comb begin
    empty                 = (cnt == '0);
    chn_in_rsc_lz         = chn_in_rsci_ld_core_psct &
                            ((cnt < DEPTH_C) | (chn_in_rsci_oswt & core_wen));
    accept                = chn_in_rsc_vz & chn_in_rsc_lz;
    chn_in_rsci_bawt      = ~empty | accept;
    pop                   = chn_in_rsci_oswt & core_wen & chn_in_rsci_bawt;
    chn_in_rsci_wen_comp  = ~chn_in_rsci_oswt | chn_in_rsci_bawt;
    chn_in_rsci_d_mxwt    = empty ? chn_in_rsc_z : mem[head];
    // An empty buffer consumed in the same cycle passes the word straight through
    wr_en                 = accept & ~(empty & pop);
    rd_en                 = pop & ~empty;
    chn_in_rsci_cnt       = cnt;
    chn_in_rsci_stall_cnt = stall_cnt;
  end

  // Storage array; contents are meaningless until written, so no reset
  always_ff @(posedge nvdla_core_clk) begin
    if (wr_en) begin
      mem[tail] <= chn_in_rsc_z;
    end
  end

  // Pointers and occupancy; simultaneous write and read leaves the count unchanged
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (wr_en) begin
        tail <= ptr_next(tail);
      end
      if (rd_en) begin
        head <= ptr_next(head);
      end
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Count cycles the core waits on this channel alone; cleared once a word is consumed
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      stall_cnt <= '0;
    end else if (pop) begin
      stall_cnt <= '0;
    end else if (chn_in_rsci_oswt & ~chn_in_rsci_bawt & ~core_wten) begin
      if (stall_cnt != 16'hFFFF) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_hls_core_chn_in_rsci_fifo.sv
// tb/tb_hls_core_chn_in_rsci_fifo.sv - self-checking bench for hls_core_chn_in_rsci_fifo
module tb_hls_core_chn_in_rsci_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [16:0] z = '0;
  logic        vz = 1'b0;
  logic        lz;
  logic        oswt = 1'b0;
  logic        wen = 1'b0;
  logic        wten = 1'b0;
  logic        psct = 1'b0;
  logic        bawt;
  logic        wen_comp;
  logic [16:0] d_mxwt;
  logic [1:0]  cnt;
  logic [15:0] stall_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [16:0] sb_q[$];

  always #5 clk = ~clk;

  hls_core_chn_in_rsci_fifo #(.WIDTH(17), .DEPTH(2)) dut (
    .nvdla_core_clk          (clk),
    .nvdla_core_rst          (rst),
    .chn_in_rsc_z            (z),
    .chn_in_rsc_vz           (vz),
    .chn_in_rsc_lz           (lz),
    .chn_in_rsci_oswt        (oswt),
    .core_wen                (wen),
    .core_wten               (wten),
    .chn_in_rsci_ld_core_psct(psct),
    .chn_in_rsci_bawt        (bawt),
    .chn_in_rsci_wen_comp    (wen_comp),
    .chn_in_rsci_d_mxwt      (d_mxwt),
    .chn_in_rsci_cnt         (cnt),
    .chn_in_rsci_stall_cnt   (stall_cnt)
  );

  typedef struct packed {
    logic        psct, oswt, wen, wten, vz;
    logic [16:0] z;
    logic        lz, bawt, wc;
    logic [16:0] d;
    logic [1:0]  cnt;
    logic [15:0] stall;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input logic p, input logic o, input logic w, input logic t,
                       input logic v, input logic [16:0] zz);
    psct = p; oswt = o; wen = w; wten = t; vz = v; z = zz;
    #1;
  endtask

  // Scoreboard: push accepted words, compare consumed words, then advance one clock
  task automatic tick();
    if (vz && lz) sb_q.push_back(z);
    if (oswt && wen && bawt) begin
      if (sb_q.size() == 0) chk("pop_on_empty_model", 32'd1, 32'd0);
      else chk("sb_order", 32'(d_mxwt), 32'(sb_q.pop_front()));
    end
    @(posedge clk); #1;
    chk("sb_cnt", 32'(cnt), 32'(sb_q.size()));
  endtask

  initial begin
    tbl[0] = '{1'b1,1'b1,1'b1,1'b0,1'b1,17'h000A5, 1'b1,1'b1,1'b1,17'h000A5,2'd0,16'd0};
    tbl[1] = '{1'b1,1'b0,1'b1,1'b0,1'b1,17'h00001, 1'b1,1'b1,1'b1,17'h00001,2'd0,16'd0};
    tbl[2] = '{1'b1,1'b0,1'b1,1'b0,1'b1,17'h00002, 1'b1,1'b1,1'b1,17'h00001,2'd1,16'd0};
    tbl[3] = '{1'b1,1'b0,1'b1,1'b0,1'b1,17'h00003, 1'b0,1'b1,1'b1,17'h00001,2'd2,16'd0};
    tbl[4] = '{1'b1,1'b1,1'b1,1'b0,1'b1,17'h00003, 1'b1,1'b1,1'b1,17'h00001,2'd2,16'd0};
    tbl[5] = '{1'b1,1'b1,1'b1,1'b0,1'b0,17'h1FFFF, 1'b1,1'b1,1'b1,17'h00002,2'd2,16'd0};
    tbl[6] = '{1'b1,1'b1,1'b1,1'b0,1'b0,17'h1FFFF, 1'b1,1'b1,1'b1,17'h00003,2'd1,16'd0};
    tbl[7] = '{1'b1,1'b1,1'b1,1'b0,1'b0,17'h0BEEF, 1'b1,1'b0,1'b0,17'h0BEEF,2'd0,16'd0};
    tbl[8] = '{1'b0,1'b0,1'b1,1'b0,1'b1,17'h00777, 1'b0,1'b0,1'b1,17'h00777,2'd0,16'd1};

    // Reset state
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 17'h00155);
    @(posedge clk); @(posedge clk); #1;
    chk("rst_lz", 32'(lz), 32'd1);
    chk("rst_bawt", 32'(bawt), 32'd1);
    chk("rst_d", 32'(d_mxwt), 32'h155);
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    rst = 1'b0;

    // Table: bypass, fill to full, hold-off, drain in order, starvation, psct gating
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].psct, tbl[i].oswt, tbl[i].wen, tbl[i].wten, tbl[i].vz, tbl[i].z);
      chk($sformatf("tbl%0d_lz", i), 32'(lz), 32'(tbl[i].lz));
      chk($sformatf("tbl%0d_bawt", i), 32'(bawt), 32'(tbl[i].bawt));
      chk($sformatf("tbl%0d_wen_comp", i), 32'(wen_comp), 32'(tbl[i].wc));
      chk($sformatf("tbl%0d_d", i), 32'(d_mxwt), 32'(tbl[i].d));
      chk($sformatf("tbl%0d_cnt", i), 32'(cnt), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_stall", i), 32'(stall_cnt), 32'(tbl[i].stall));
      tick();
    end

    // Full pass-through with pointer wrap
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 17'h00050); tick();
    chk("pre_full_stall_clr", 32'(stall_cnt), 32'd0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 17'h00010); tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 17'h00011); tick();
    chk("full_cnt", 32'(cnt), 32'd2);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 17'h00012 + 17'(i));
      chk($sformatf("pass%0d_lz", i), 32'(lz), 32'd1);
      tick();
      chk($sformatf("pass%0d_cnt", i), 32'(cnt), 32'd2);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 17'h0); tick();
    tick();
    chk("drained_cnt", 32'(cnt), 32'd0);

    // Starvation: five counted cycles, one held by wten, cleared after a pop
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 17'h0);
      chk($sformatf("starve%0d_bawt", i), 32'(bawt), 32'd0);
      chk($sformatf("starve%0d_wc", i), 32'(wen_comp), 32'd0);
      tick();
    end
    chk("starve_cnt5", 32'(stall_cnt), 32'd5);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 17'h0); tick();
    chk("starve_wten_hold", 32'(stall_cnt), 32'd5);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 17'h00ABC); tick();
    chk("starve_clear", 32'(stall_cnt), 32'd0);

    // Saturation
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 17'h0);
    repeat (70000) @(posedge clk);
    #1;
    chk("stall_sat", 32'(stall_cnt), 32'hFFFF);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 17'h00DEF); tick();
    chk("sat_clear", 32'(stall_cnt), 32'd0);

    // Reset mid-operation with occupancy 2 and nonzero stall
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 17'h0); tick();
    end
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 17'h00021); tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 17'h00022); tick();
    chk("prerst_cnt", 32'(cnt), 32'd2);
    chk("prerst_stall", 32'(stall_cnt), 32'd3);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 17'h00033);
    rst = 1'b1; #1;
    chk("midrst_cnt", 32'(cnt), 32'd0);
    chk("midrst_stall", 32'(stall_cnt), 32'd0);
    chk("midrst_bawt_novz", 32'(bawt), 32'd0);
    chk("midrst_d", 32'(d_mxwt), 32'h33);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 17'h00044);
    chk("midrst_bawt_vz", 32'(bawt), 32'd1);
    chk("midrst_d_vz", 32'(d_mxwt), 32'h44);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 17'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();

    // First edges after reset operate normally, no stale words
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 17'h00055); tick();
    chk("postrst_cnt", 32'(cnt), 32'd1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 17'h0);
    chk("postrst_d", 32'(d_mxwt), 32'h55);
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
